pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage static pipeline.
//  - Drives W_ena and bubble (clear) controls of PC and IF/ID, ID/EX, EX/MEM, MEM/WB regs.
//  - Detects RAW hazards against EXE/MEM destinations; holds EXE for multi-cycle MUL/DIV.
//  - Squashes the fetched instruction on a taken branch; counts stall cycles for perf.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 27 ++
 rtl/pipe_hazard_ctrl_md_cycle_counter.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// register-zero constant, multi-cycle defaults and the RAW compare helper.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam int         MUL_CYCLES_DEF = 4;
    localparam int         DIV_CYCLES_DEF = 32;
    localparam int         CNT_W          = 6;

    // $0 is hardwired, so a write to it can never create a dependency.
    function automatic logic raw_match(
        input logic [4:0] dest,
        input logic [4:0] rs_addr,
        input logic [4:0] rt_addr,
        input logic       rs_used,
        input logic       rt_used
    );
        return (dest != REG_ZERO) &&
               ((rs_used && (rs_addr == dest)) || (rt_used && (rt_addr == dest)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_cycle_counter.sv
// Down-counter tracking the remaining EXE occupancy of a MUL/DIV instruction.
module md_cycle_counter
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: MUL/DIV hold, RAW stalls,
// taken-branch squash and a stall-cycle performance counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int FORWARDING = 1,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_rs_addr,
    input  logic [4:0]  ID_rt_addr,
    input  logic        ID_rs_used,
    input  logic        ID_rt_used,
    input  logic        ID_branch_taken,
    input  logic        EXE_RF_W_ena,
    input  logic [4:0]  EXE_RF_waddr,
    input  logic        EXE_is_load,
    input  logic        MEM_RF_W_ena,
    input  logic [4:0]  MEM_RF_waddr,
    input  logic        EXE_md_start,
    input  logic        EXE_md_is_div,
    output logic        PC_W_ena,
    output logic        IF_ID_W_ena,
    output logic        IF_ID_flush,
    output logic        ID_EX_W_ena,
    output logic        ID_EX_bubble,
    output logic        EX_MEM_W_ena,
    output logic        EX_MEM_bubble,
    output logic        MEM_WB_W_ena,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cycles
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           state, next_state;
    logic             cnt_load, cnt_dec, cnt_last;
    logic [CNT_W-1:0] cnt, cnt_load_val;
    logic             md_stall, md_done_i, md_busy_i;
    logic             exe_match, mem_match, ld_stall;

    md_cycle_counter u_md_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .last     (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // EXE_md_start is deliberately ignored in MD_BUSY: the same instruction
    // is still sitting in EXE and keeps asserting it.
    always_comb begin
        next_state   = state;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = EXE_md_is_div ? DIV_LOAD : MUL_LOAD;
        md_stall     = 1'b0;
        md_done_i    = 1'b0;
        md_busy_i    = 1'b0;
        case (state)
            ST_RUN: begin
                if (EXE_md_start) begin
                    cnt_load   = 1'b1;
                    md_stall   = 1'b1;
                    md_busy_i  = 1'b1;
                    next_state = ST_MD_BUSY;
                end
            end
            ST_MD_BUSY: begin
                cnt_dec   = 1'b1;
                md_busy_i = 1'b1;
                md_stall  = !cnt_last;
                if (cnt_last) begin
                    md_done_i  = 1'b1;
                    next_state = ST_RUN;
                end
            end
            default: next_state = ST_RUN;
        endcase
    end

    always_comb begin
        exe_match = EXE_RF_W_ena &&
                    raw_match(EXE_RF_waddr, ID_rs_addr, ID_rt_addr, ID_rs_used, ID_rt_used);
        mem_match = MEM_RF_W_ena &&
                    raw_match(MEM_RF_waddr, ID_rs_addr, ID_rt_addr, ID_rs_used, ID_rt_used);
        if (FORWARDING != 0) begin
            ld_stall = exe_match && EXE_is_load;
        end else begin
            ld_stall = exe_match || mem_match;
        end
    end

    // Outputs are forced low while reset is held so the pipeline freezes at once.
    always_comb begin
        PC_W_ena      = 1'b1;
        IF_ID_W_ena   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_W_ena   = 1'b1;
        ID_EX_bubble  = 1'b0;
        EX_MEM_W_ena  = 1'b1;
        EX_MEM_bubble = 1'b0;
        MEM_WB_W_ena  = 1'b1;
        md_busy       = md_busy_i;
        md_done       = md_done_i;
        if (md_stall) begin
            PC_W_ena      = 1'b0;
            IF_ID_W_ena   = 1'b0;
            ID_EX_W_ena   = 1'b0;
            EX_MEM_bubble = 1'b1;
        end else if (ld_stall) begin
            PC_W_ena     = 1'b0;
            IF_ID_W_ena  = 1'b0;
            ID_EX_bubble = 1'b1;
        end else if (ID_branch_taken) begin
            IF_ID_flush = 1'b1;
        end
        if (rst) begin
            PC_W_ena      = 1'b0;
            IF_ID_W_ena   = 1'b0;
            IF_ID_flush   = 1'b0;
            ID_EX_W_ena   = 1'b0;
            ID_EX_bubble  = 1'b0;
            EX_MEM_W_ena  = 1'b0;
            EX_MEM_bubble = 1'b0;
            MEM_WB_W_ena  = 1'b0;
            md_busy       = 1'b0;
            md_done       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (!PC_W_ena) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: hazard vector table plus
// hand-written MUL/DIV and reset sequences, checked through a scoreboard queue.
module tb_pipe_hazard_ctrl;

    localparam logic [9:0] V_ZERO    = 10'b0000000000;
    localparam logic [9:0] V_NORM    = 10'b1101010100;
    localparam logic [9:0] V_LD      = 10'b0001110100;
    localparam logic [9:0] V_BR      = 10'b1111010100;
    localparam logic [9:0] V_MD      = 10'b0000011110;
    localparam logic [9:0] V_DONE    = 10'b1101010111;
    localparam logic [9:0] V_DONE_LD = 10'b0001110111;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_rs_addr, ID_rt_addr, EXE_RF_waddr, MEM_RF_waddr;
    logic        ID_rs_used, ID_rt_used, ID_branch_taken;
    logic        EXE_RF_W_ena, EXE_is_load, MEM_RF_W_ena, EXE_md_start, EXE_md_is_div;
    logic        PC_W_ena, IF_ID_W_ena, IF_ID_flush, ID_EX_W_ena, ID_EX_bubble;
    logic        EX_MEM_W_ena, EX_MEM_bubble, MEM_WB_W_ena, md_busy, md_done;
    logic [31:0] stall_cycles;
    logic        nf_pc, nf_ifw, nf_fl, nf_idw, nf_idb, nf_exw, nf_exb, nf_mwb, nf_busy, nf_done;
    logic [31:0] nf_stall;
    logic [9:0]  dut_vec;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FORWARDING(1), .MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk(clk), .rst(rst),
        .ID_rs_addr(ID_rs_addr), .ID_rt_addr(ID_rt_addr),
        .ID_rs_used(ID_rs_used), .ID_rt_used(ID_rt_used),
        .ID_branch_taken(ID_branch_taken),
        .EXE_RF_W_ena(EXE_RF_W_ena), .EXE_RF_waddr(EXE_RF_waddr), .EXE_is_load(EXE_is_load),
        .MEM_RF_W_ena(MEM_RF_W_ena), .MEM_RF_waddr(MEM_RF_waddr),
        .EXE_md_start(EXE_md_start), .EXE_md_is_div(EXE_md_is_div),
        .PC_W_ena(PC_W_ena), .IF_ID_W_ena(IF_ID_W_ena), .IF_ID_flush(IF_ID_flush),
        .ID_EX_W_ena(ID_EX_W_ena), .ID_EX_bubble(ID_EX_bubble),
        .EX_MEM_W_ena(EX_MEM_W_ena), .EX_MEM_bubble(EX_MEM_bubble),
        .MEM_WB_W_ena(MEM_WB_W_ena), .md_busy(md_busy), .md_done(md_done),
        .stall_cycles(stall_cycles)
    );

    pipe_hazard_ctrl #(.FORWARDING(0), .MUL_CYCLES(4), .DIV_CYCLES(32)) dut_nf (
        .clk(clk), .rst(rst),
        .ID_rs_addr(ID_rs_addr), .ID_rt_addr(ID_rt_addr),
        .ID_rs_used(ID_rs_used), .ID_rt_used(ID_rt_used),
        .ID_branch_taken(ID_branch_taken),
        .EXE_RF_W_ena(EXE_RF_W_ena), .EXE_RF_waddr(EXE_RF_waddr), .EXE_is_load(EXE_is_load),
        .MEM_RF_W_ena(MEM_RF_W_ena), .MEM_RF_waddr(MEM_RF_waddr),
        .EXE_md_start(EXE_md_start), .EXE_md_is_div(EXE_md_is_div),
        .PC_W_ena(nf_pc), .IF_ID_W_ena(nf_ifw), .IF_ID_flush(nf_fl),
        .ID_EX_W_ena(nf_idw), .ID_EX_bubble(nf_idb),
        .EX_MEM_W_ena(nf_exw), .EX_MEM_bubble(nf_exb),
        .MEM_WB_W_ena(nf_mwb), .md_busy(nf_busy), .md_done(nf_done),
        .stall_cycles(nf_stall)
    );

    assign dut_vec = {PC_W_ena, IF_ID_W_ena, IF_ID_flush, ID_EX_W_ena, ID_EX_bubble,
                      EX_MEM_W_ena, EX_MEM_bubble, MEM_WB_W_ena, md_busy, md_done};

    typedef struct {
        string      name;
        logic [4:0] rs, rt;
        logic       rs_used, rt_used, br;
        logic       exe_w;
        logic [4:0] exe_wa;
        logic       exe_ld;
        logic       mem_w;
        logic [4:0] mem_wa;
        logic [9:0] exp;
        logic       exp_nf_pc;
    } vec_t;

    typedef struct {
        string       name;
        logic [9:0]  exp;
        logic        exp_nf_pc;
        logic [31:0] exp_stall;
    } sb_t;

    vec_t        tbl[11];
    sb_t         sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_stall = 0;

    task automatic check_vec(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s outputs actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ID_rs_addr = 0; ID_rt_addr = 0; ID_rs_used = 0; ID_rt_used = 0;
        ID_branch_taken = 0; EXE_RF_W_ena = 0; EXE_RF_waddr = 0; EXE_is_load = 0;
        MEM_RF_W_ena = 0; MEM_RF_waddr = 0; EXE_md_start = 0; EXE_md_is_div = 0;
    endtask

    // Inputs are already driven (posedge+1); push expectation, compare at negedge.
    task automatic step(input string name, input logic [9:0] exp, input logic exp_nf_pc);
        sb_t e;
        sb_t got;
        e.name = name; e.exp = exp; e.exp_nf_pc = exp_nf_pc; e.exp_stall = exp_stall;
        sb_q.push_back(e);
        if (!exp[9]) exp_stall = exp_stall + 32'd1;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s scoreboard empty actual=0 required=1", name);
        end else begin
            got = sb_q.pop_front();
            check_vec(got.name, dut_vec, got.exp);
            check_val({got.name, "_nf_pc"}, {31'd0, nf_pc}, {31'd0, got.exp_nf_pc});
            check_val({got.name, "_stall_cycles"}, stall_cycles, got.exp_stall);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit actual=expired required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{"normal",        5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, V_NORM, 1'b1};
        tbl[1]  = '{"load_use_rs",   5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, V_LD,   1'b0};
        tbl[2]  = '{"load_use_rt",   5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, V_LD,   1'b0};
        tbl[3]  = '{"load_r0",       5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, V_NORM, 1'b1};
        tbl[4]  = '{"alu_exe_match", 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, V_NORM, 1'b0};
        tbl[5]  = '{"mem_match",     5'd9, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, V_NORM, 1'b0};
        tbl[6]  = '{"rs_unused",     5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, V_NORM, 1'b1};
        tbl[7]  = '{"branch",        5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, V_BR,   1'b1};
        tbl[8]  = '{"branch_ld",     5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 5'd0, V_LD,   1'b0};
        tbl[9]  = '{"exe_no_write",  5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, V_NORM, 1'b1};
        tbl[10] = '{"mem_no_write",  5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd8, V_NORM, 1'b1};

        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        check_vec("reset_outputs", dut_vec, V_ZERO);
        check_val("reset_stall_cycles", stall_cycles, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single load-use cycle followed by a clean cycle
        ID_rs_addr = 5'd3; ID_rs_used = 1'b1;
        EXE_RF_W_ena = 1'b1; EXE_RF_waddr = 5'd3; EXE_is_load = 1'b1;
        step("first_load_use", V_LD, 1'b0);
        clear_inputs();
        step("after_load_use", V_NORM, 1'b1);

        for (int i = 0; i < 11; i++) begin
            ID_rs_addr = tbl[i].rs; ID_rt_addr = tbl[i].rt;
            ID_rs_used = tbl[i].rs_used; ID_rt_used = tbl[i].rt_used;
            ID_branch_taken = tbl[i].br;
            EXE_RF_W_ena = tbl[i].exe_w; EXE_RF_waddr = tbl[i].exe_wa; EXE_is_load = tbl[i].exe_ld;
            MEM_RF_W_ena = tbl[i].mem_w; MEM_RF_waddr = tbl[i].mem_wa;
            EXE_md_start = 1'b0; EXE_md_is_div = 1'b0;
            step(tbl[i].name, tbl[i].exp, tbl[i].exp_nf_pc);
        end
        clear_inputs();
        step("branch_released", V_NORM, 1'b1);

        // DIV: start held a few cycles to confirm it is ignored while busy
        EXE_md_start = 1'b1; EXE_md_is_div = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            if (c == 6) begin
                EXE_md_start = 1'b0; EXE_md_is_div = 1'b0;
            end
            step($sformatf("div_stall_%0d", c), V_MD, 1'b0);
        end
        step("div_done", V_DONE, 1'b1);
        step("div_after", V_NORM, 1'b1);

        // MUL start coinciding with load-use and taken branch
        EXE_md_start = 1'b1; EXE_md_is_div = 1'b0;
        ID_rs_addr = 5'd12; ID_rs_used = 1'b1; ID_branch_taken = 1'b1;
        EXE_RF_W_ena = 1'b1; EXE_RF_waddr = 5'd12; EXE_is_load = 1'b1;
        step("mul_stall_1", V_MD, 1'b0);
        EXE_md_start = 1'b0;
        step("mul_stall_2", V_MD, 1'b0);
        step("mul_stall_3", V_MD, 1'b0);
        step("mul_done_ld", V_DONE_LD, 1'b0);
        clear_inputs();
        step("mul_after", V_NORM, 1'b1);

        // Reset while DIV counter is at 10
        EXE_md_start = 1'b1; EXE_md_is_div = 1'b1;
        step("div2_start", V_MD, 1'b0);
        EXE_md_start = 1'b0; EXE_md_is_div = 1'b0;
        for (int c = 2; c <= 22; c++) begin
            step($sformatf("div2_stall_%0d", c), V_MD, 1'b0);
        end
        rst = 1'b1;
        #1;
        check_vec("mid_div_reset_outputs", dut_vec, V_ZERO);
        check_val("mid_div_reset_stall_cycles", stall_cycles, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_stall = 0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 12; c++) begin
            step($sformatf("post_reset_%0d", c), V_NORM, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
